// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encodings, ACK/NACK bit values and R/W bit position.
package i2c_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int unsigned RW_BIT = 0;

    // States in which the target shifts a byte in from the bus
    function automatic logic is_rx_state(input logic [3:0] state);
        return (state == ST_ADDR) || (state == ST_REG) || (state == ST_WDATA);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and flags scl edges plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    // Idle bus is high, so flops come out of reset high to avoid spurious edges
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_scl      = w_scl;
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
    assign o_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an internal byte register file, auto-incrementing pointer,
// host-controlled clock stretching and a write-strobe side port.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
    parameter int unsigned REG_DEPTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        scl,
    inout  wire        sda,
    input  logic       stretch_req,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_reg_ok;
    logic [7:0] w_rd_byte;

    logic [3:0]    r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_full;
    logic          r_rw;
    logic          r_mack;
    logic          r_sda_oe;
    logic          r_scl_oe;
    logic          r_busy;
    logic [AW-1:0] r_ptr;
    logic [7:0]    r_regs [REG_DEPTH];
    logic          r_wr_stb;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_wr_data;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_scl      (w_scl),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_reg_ok  = (32'(r_shift) < REG_DEPTH);
    assign w_rd_byte = r_regs[r_ptr];

    // Bits are sampled on scl rise; the byte is acted on at the following scl fall,
    // where r_full marks that eight bits have been seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_full    <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= I2C_NACK;
            r_sda_oe  <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_regs    <= '{default: '0};
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_bitcnt <= '0;
                r_full   <= 1'b0;
            end else if (w_start) begin
                r_state  <= ST_ADDR;
                r_sda_oe <= 1'b0;
                r_bitcnt <= '0;
                r_full   <= 1'b0;
            end else if (w_scl_rise) begin
                if (is_rx_state(r_state) || (r_state == ST_RDATA)) begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                    r_full   <= (r_bitcnt == 3'd7);
                end
                if (is_rx_state(r_state)) r_shift <= {r_shift[6:0], w_sda};
                if (r_state == ST_RDATA_ACK) r_mack <= w_sda;
            end else if (w_scl_fall) begin
                r_full <= 1'b0;
                case (r_state)
                    ST_ADDR: if (r_full) begin
                        if (r_shift[7:1] == SLAVE_ADDR) begin
                            r_sda_oe <= 1'b1;
                            r_busy   <= 1'b1;
                            r_rw     <= r_shift[RW_BIT];
                            r_state  <= ST_ADDR_ACK;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ADDR_ACK: begin
                        r_bitcnt <= '0;
                        if (r_rw) begin
                            r_shift  <= w_rd_byte;
                            r_sda_oe <= ~w_rd_byte[7];
                            r_state  <= ST_RDATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_REG;
                        end
                    end
                    ST_REG: if (r_full) begin
                        if (w_reg_ok) begin
                            r_ptr    <= r_shift[AW-1:0];
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_REG_ACK;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_REG_ACK, ST_WDATA_ACK: begin
                        r_sda_oe <= 1'b0;
                        r_state  <= ST_WDATA;
                    end
                    ST_WDATA: if (r_full) begin
                        r_regs[r_ptr] <= r_shift;
                        r_wr_stb      <= 1'b1;
                        r_wr_addr     <= 8'(r_ptr);
                        r_wr_data     <= r_shift;
                        r_ptr         <= r_ptr + 1'b1;
                        r_sda_oe      <= 1'b1;
                        r_state       <= ST_WDATA_ACK;
                    end
                    ST_RDATA: begin
                        if (r_full) begin
                            r_sda_oe <= 1'b0;
                            r_ptr    <= r_ptr + 1'b1;
                            r_state  <= ST_RDATA_ACK;
                        end else begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (r_mack == I2C_ACK) begin
                            r_bitcnt <= '0;
                            r_shift  <= w_rd_byte;
                            r_sda_oe <= ~w_rd_byte[7];
                            r_state  <= ST_RDATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end

            // STOP overrides a pending stretch; scl is only grabbed while already low
            if (w_stop || !stretch_req || !r_busy || (r_state == ST_IDLE)) begin
                r_scl_oe <= 1'b0;
            end else if (!w_scl) begin
                r_scl_oe <= 1'b1;
            end
        end
    end

    assign scl     = r_scl_oe ? 1'b0 : 1'bz;
    assign sda     = r_sda_oe ? 1'b0 : 1'bz;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

endmodule
